csr_file: RTL

- Machine-mode CSR register file for the RV64 core: holds the writable CSR state, decodes reads, applies CSRRW/CSRRS/CSRRC updates, and captures trap/mret state.
- Sits beside the execute stage. Read data is combinational from the current state. Updates commit on the rising clock edge.
- Replaces a pure read decoder with a stateful block: atomic read-modify-write, trap entry, MRET and an illegal-access flag.

---
 rtl/csr_pkg.sv | 35 +++
 rtl/csr_counter.sv | 30 +++
 rtl/csr_file.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encoding, mstatus layout.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_t;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] MXL_64 = 2'b10;
    localparam logic [1:0] MPP_M  = 2'b11;

endpackage

// File: rtl/csr_counter.sv
// Free-running N-bit counter with a parallel load that takes priority over increment.
module csr_counter #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         inc,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] value
);

    logic [N-1:0] count_r;

    // count register: load beats increment, wraps naturally at 2^N
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {N{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (inc) begin
            count_r <= count_r + {{(N-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign value = count_r;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with RMW updates, trap entry and MRET.
// Optional mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file
    import csr_pkg::*;
#(
    parameter int          N        = 64,
    parameter int unsigned HARTID   = 0,
    parameter logic [25:0] MISA_EXT = 26'h0000100
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         csr_en,
    input  logic [1:0]   csr_op,
    input  logic [11:0]  csr_addr,
    input  logic [N-1:0] csr_wdata,
    output logic [N-1:0] csr_rdata,
    output logic         csr_illegal,
    input  logic         trap_valid,
    input  logic [N-1:0] trap_pc,
    input  logic [N-1:0] trap_cause,
    input  logic [N-1:0] trap_val,
    input  logic         mret,
    input  logic         instret_inc,
    output logic [N-1:0] mtvec_out,
    output logic [N-1:0] mepc_out,
    output logic         mie_out
);

    csr_op_t      op_s;
    logic [N-1:0] old_s, new_s, mstatus_s, misa_s;
    logic         impl_s, ro_s, write_req_s, illegal_s, commit_s;
    logic [N-1:0] mtvec_r, mepc_r, mcause_r, mtval_r, mscratch_r;
    logic         mie_r, mpie_r;
`ifdef CSR_COUNTERS_EN
    logic [N-1:0] mcycle_s, minstret_s;
    logic         mcycle_ld_s, minstret_ld_s;
`endif

    function automatic logic [N-1:0] rmw(input csr_op_t op, input logic [N-1:0] old,
                                         input logic [N-1:0] wd);
        case (op)
            CSR_OP_RW: rmw = wd;
            CSR_OP_RS: rmw = old | wd;
            CSR_OP_RC: rmw = old & ~wd;
            default:   rmw = old;
        endcase
    endfunction

    assign op_s = csr_op_t'(csr_op);

    // assemble the composite read views of mstatus and misa
    always_comb begin
        mstatus_s = {N{1'b0}};
        mstatus_s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MPP_M;
        mstatus_s[MSTATUS_MIE]  = mie_r;
        mstatus_s[MSTATUS_MPIE] = mpie_r;
        misa_s = {N{1'b0}};
        misa_s[N-1:N-2] = MXL_64;
        misa_s[25:0]    = MISA_EXT;
    end

    // address decode: old value, implemented and read-only flags
    always_comb begin
        old_s  = {N{1'b0}};
        impl_s = 1'b1;
        ro_s   = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:  old_s = mstatus_s;
            CSR_MISA:     begin old_s = misa_s; ro_s = 1'b1; end
            CSR_MTVEC:    old_s = mtvec_r;
            CSR_MSCRATCH: old_s = mscratch_r;
            CSR_MEPC:     old_s = mepc_r;
            CSR_MCAUSE:   old_s = mcause_r;
            CSR_MTVAL:    old_s = mtval_r;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: ro_s = 1'b1;
            CSR_MHARTID:  begin old_s = N'(HARTID); ro_s = 1'b1; end
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:   old_s = mcycle_s;
            CSR_MINSTRET: old_s = minstret_s;
            CSR_CYCLE:    begin old_s = mcycle_s; ro_s = 1'b1; end
            CSR_INSTRET:  begin old_s = minstret_s; ro_s = 1'b1; end
`endif
            default:      impl_s = 1'b0;
        endcase
    end

    // write qualification; set/clear with a zero mask never writes
    always_comb begin
        write_req_s = 1'b0;
        if (csr_en && (op_s != CSR_OP_NONE)) begin
            if (((op_s == CSR_OP_RS) || (op_s == CSR_OP_RC)) && (csr_wdata == {N{1'b0}})) begin
                write_req_s = 1'b0;
            end else begin
                write_req_s = 1'b1;
            end
        end else begin
            write_req_s = 1'b0;
        end
        illegal_s = csr_en && (op_s != CSR_OP_NONE) && (!impl_s || (write_req_s && ro_s));
        commit_s  = write_req_s && !illegal_s && !trap_valid && !mret;
        new_s     = rmw(op_s, old_s, csr_wdata);
    end

    assign csr_rdata   = illegal_s ? {N{1'b0}} : old_s;
    assign csr_illegal = illegal_s;

    // architectural state: trap > mret > CSR write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtvec_r    <= {N{1'b0}};
            mepc_r     <= {N{1'b0}};
            mcause_r   <= {N{1'b0}};
            mtval_r    <= {N{1'b0}};
            mscratch_r <= {N{1'b0}};
            mie_r      <= 1'b0;
            mpie_r     <= 1'b0;
        end else if (trap_valid) begin
            mepc_r   <= trap_pc & {{(N-1){1'b1}}, 1'b0};
            mcause_r <= trap_cause;
            mtval_r  <= trap_val;
            mpie_r   <= mie_r;
            mie_r    <= 1'b0;
        end else if (mret) begin
            mie_r  <= mpie_r;
            mpie_r <= 1'b1;
        end else if (commit_s) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_r  <= new_s[MSTATUS_MIE];
                    mpie_r <= new_s[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_r    <= new_s & {{(N-2){1'b1}}, 2'b00};
                CSR_MSCRATCH: mscratch_r <= new_s;
                CSR_MEPC:     mepc_r     <= new_s & {{(N-1){1'b1}}, 1'b0};
                CSR_MCAUSE:   mcause_r   <= new_s;
                CSR_MTVAL:    mtval_r    <= new_s;
                default:      ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    assign mcycle_ld_s   = commit_s && (csr_addr == CSR_MCYCLE);
    assign minstret_ld_s = commit_s && (csr_addr == CSR_MINSTRET);

    csr_counter #(.N(N)) u_mcycle (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (mcycle_ld_s),
        .inc        (1'b1),
        .load_value (new_s),
        .value      (mcycle_s)
    );

    csr_counter #(.N(N)) u_minstret (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (minstret_ld_s),
        .inc        (instret_inc),
        .load_value (new_s),
        .value      (minstret_s)
    );
`else
    logic unused_s;
    assign unused_s = instret_inc;
`endif

    assign mtvec_out = mtvec_r;
    assign mepc_out  = mepc_r;
    assign mie_out   = mie_r;

endmodule
